// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M multi-cycle divider.
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring radix-2 division iteration.
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  // Since rem < divisor, the trial fits in WIDTH+1 bits with bit WIDTH as sign.
  assign w_rem_sh = {rem, quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, divisor};

  assign next_rem = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign next_quo = {quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU responder with stall/done handshake.
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_result;

  logic             w_idle_or_done;
  logic             w_accept;
  logic             w_signed;
  logic             w_sel_rem;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH-1:0] w_fix_res;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_accept       = start && !kill && w_idle_or_done;

  assign w_signed  = (op == DIV) || (op == REM);
  assign w_sel_rem = (op == REM) || (op == REMU);
  assign w_a_neg   = w_signed && dividend[WIDTH-1];
  assign w_b_neg   = w_signed && divisor[WIDTH-1];
  assign w_abs_a   = w_a_neg ? -dividend : dividend;
  assign w_abs_b   = w_b_neg ? -divisor : divisor;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_div0 = (divisor == '0);
  assign w_ovf  = w_signed && (dividend == C_MIN) && (divisor == '1);

  always_comb begin
    w_spec_res = '0;
    if (w_div0) begin
      w_spec_res = w_sel_rem ? dividend : '1;
    end else begin
      w_spec_res = w_sel_rem ? '0 : C_MIN;
    end
  end

  assign w_fix_res = r_sel_rem ? (r_neg_r ? -r_rem : r_rem)
                               : (r_neg_q ? -r_quo : r_quo);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_dvs),
    .next_rem (w_next_rem),
    .next_quo (w_next_quo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else if (kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_sel_rem <= w_sel_rem;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_dvs     <= w_abs_b;
            r_cnt     <= CNT_W'(WIDTH - 1);
            if (w_div0 || w_ovf) begin
              r_result <= w_spec_res;
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix_res;
          r_state  <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall  = w_accept || (r_state == CALC) || (r_state == FIX);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with an expected-result queue.
`default_nettype none

module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         stall;
  logic         done;
  logic [W-1:0] result;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller is positioned just after a falling edge; start is held for exactly one cycle.
  task automatic run_op(input string tag, input div_op_t o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    int stall_lo;
    logic [W-1:0] e;
    op = o; dividend = a; divisor = b; start = 1'b1;
    exp_q.push_back(exp_res);
    #1;
    chk({tag, "_stall_c0"}, W'(stall), W'(1));
    lat = 0;
    stall_lo = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (!stall) stall_lo++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, W'(lat), W'(exp_lat));
    chk({tag, "_stall_gap"}, W'(stall_lo), W'(0));
    if (lat != 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, result, e);
    end else begin
      void'(exp_q.pop_front());
    end
    #1;
    chk({tag, "_stall_done"}, W'(stall), W'(0));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pulses;
    repeat (2) @(negedge clk);
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_result", result, '0);
    rst = 1'b1;
    idle_cycle();

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34);        idle_cycle();
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34);         idle_cycle();
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34); idle_cycle();
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34); idle_cycle();
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34); idle_cycle();
    run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34); idle_cycle();
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34); idle_cycle();
    run_op("divu_5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);      idle_cycle();
    run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 1);              idle_cycle();
    run_op("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1); idle_cycle();
    run_op("rem_m5_0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1); idle_cycle();
    run_op("div_ovf", DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1);   idle_cycle();
    run_op("rem_ovf", REM, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1);     idle_cycle();

    // Second request issued in the same cycle the first reports done.
    run_op("b2b_first", DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("b2b_second", DIVU, 32'd9, 32'd3, 32'd3, 34);
    idle_cycle();

    // Kill in cycle 10 of an in-flight operation.
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    #1;
    chk("kill_stall", W'(stall), W'(0));
    chk("kill_done", W'(done), W'(0));
    chk("kill_result", result, 32'd3);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("kill_no_done", W'(pulses), W'(0));

    // Asynchronous reset mid-CALC, away from any clock edge.
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_stall", W'(stall), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_result", result, '0);
    @(negedge clk); rst = 1'b1;
    idle_cycle();
    run_op("divu_8_2", DIVU, 32'd8, 32'd2, 32'd4, 34);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
